hdmi_pll_reconfig_seq: RTL and testbench

HDMI_PLL_RECONFIG_SEQ -- requirements
Module: hdmi_pll_reconfig_seq

---
 rtl/hdmi_pll_reconfig_seq.sv | 217 +++++++++++++++++++++
 tb/tb_hdmi_pll_reconfig_seq.sv | 525 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_pll_reconfig_seq.sv
// HDMI PLL reconfiguration sequencer: writes divider settings over the
// reconfig management bus, then waits for the PLL to drop and regain lock.
module hdmi_pll_reconfig_seq #(
  parameter int unsigned LOCK_STABLE  = 16,
  parameter int unsigned LOCK_TIMEOUT = 1000000,
  parameter int unsigned DROP_WAIT    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [8:0]  cfg_m,
  input  logic [8:0]  cfg_n,
  input  logic [8:0]  cfg_c0,
  input  logic [31:0] cfg_frac,
  output logic [5:0]  mgmt_address,
  output logic        mgmt_write,
  output logic [31:0] mgmt_writedata,
  input  logic        mgmt_waitrequest,
  input  logic        pll_locked,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int SW = $clog2(LOCK_STABLE + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int DW = $clog2(DROP_WAIT + 1);

  localparam logic [SW-1:0] STAB_LAST = SW'(LOCK_STABLE - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(LOCK_TIMEOUT - 1);
  localparam logic [DW-1:0] DROP_LAST = DW'(DROP_WAIT - 1);

  typedef enum logic [3:0] {
    IDLE,
    WR_MODE,
    WR_N,
    WR_M,
    WR_C,
    WR_K,
    WR_START,
    WAIT_DROP,
    WAIT_LOCK,
    FINISH
  } state_t;

  state_t state;
  state_t state_nx;

  logic          up;
  logic          lk_m;
  logic          lk_s;
  logic          gap;
  logic          gap_nx;
  logic          err_q;
  logic          err_nx;
  logic [8:0]    m_q;
  logic [8:0]    n_q;
  logic [8:0]    c_q;
  logic [31:0]   k_q;
  logic [SW-1:0] stab_cnt;
  logic [TW-1:0] to_cnt;
  logic [DW-1:0] drop_cnt;

  logic          accept;
  logic          bad_cfg;
  logic          load;
  logic          stab_hit;
  logic          to_hit;
  logic          drop_hit;
  logic          wr_en;
  logic [5:0]    wr_addr;
  logic [31:0]   wr_data;
  state_t        wr_next;

  // Bit 17 = odd, bit 16 = bypass; a 256 high count wraps to 0.
  function automatic logic [31:0] enc(input logic [8:0] d);
    logic [7:0] lo;
    logic [7:0] hi;
    lo = d[8:1];
    hi = d[7:0] - lo;
    if (d == 9'd1) enc = 32'h0001_0000;
    else enc = {14'b0, d[0], 1'b0, hi, lo};
  endfunction

  assign cfg_ready = up && (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == FINISH);
  assign err       = err_q;

  assign accept  = cfg_valid && cfg_ready;
  assign bad_cfg = (cfg_m == '0) || (cfg_n == '0) || (cfg_c0 == '0);
  assign load    = accept && !bad_cfg;

  assign stab_hit = (state == WAIT_LOCK) && lk_s &&
                    (stab_cnt == STAB_LAST);
  assign to_hit   = (state == WAIT_LOCK) && (to_cnt == TO_LAST);
  assign drop_hit = (state == WAIT_DROP) && (drop_cnt == DROP_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gap      <= 1'b0;
      up       <= 1'b0;
      lk_m     <= 1'b0;
      lk_s     <= 1'b0;
      err_q    <= 1'b0;
      stab_cnt <= '0;
      to_cnt   <= '0;
      drop_cnt <= '0;
      m_q      <= '0;
      n_q      <= '0;
      c_q      <= '0;
      k_q      <= '0;
    end else begin
      state <= state_nx;
      gap   <= gap_nx;
      up    <= 1'b1;
      lk_m  <= pll_locked;
      lk_s  <= lk_m;
      err_q <= err_nx;
      stab_cnt <= (state == WAIT_LOCK && lk_s && !stab_hit) ?
                  stab_cnt + SW'(1) : '0;
      to_cnt   <= (state == WAIT_LOCK && !to_hit) ?
                  to_cnt + TW'(1) : '0;
      drop_cnt <= (state == WAIT_DROP && !drop_hit) ?
                  drop_cnt + DW'(1) : '0;
      if (load) begin
        m_q <= cfg_m;
        n_q <= cfg_n;
        c_q <= cfg_c0;
        k_q <= cfg_frac;
      end
    end
  end

  always_comb begin
    state_nx       = state;
    gap_nx         = 1'b0;
    err_nx         = 1'b0;
    wr_en          = 1'b0;
    wr_addr        = '0;
    wr_data        = '0;
    wr_next        = state;
    mgmt_write     = 1'b0;
    mgmt_address   = '0;
    mgmt_writedata = '0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (bad_cfg) err_nx = 1'b1;
          else state_nx = WR_MODE;
        end
      end
      WR_MODE: begin
        wr_en   = 1'b1;
        wr_addr = 6'd0;
        wr_data = 32'd0;
        wr_next = WR_N;
      end
      WR_N: begin
        wr_en   = 1'b1;
        wr_addr = 6'd3;
        wr_data = enc(n_q);
        wr_next = WR_M;
      end
      WR_M: begin
        wr_en   = 1'b1;
        wr_addr = 6'd4;
        wr_data = enc(m_q);
        wr_next = WR_C;
      end
      WR_C: begin
        wr_en   = 1'b1;
        wr_addr = 6'd5;
        wr_data = enc(c_q) & ~32'h007C_0000;
        wr_next = WR_K;
      end
      WR_K: begin
        wr_en   = 1'b1;
        wr_addr = 6'd7;
        wr_data = k_q;
        wr_next = WR_START;
      end
      WR_START: begin
        wr_en   = 1'b1;
        wr_addr = 6'd2;
        wr_data = 32'd1;
        wr_next = WAIT_DROP;
      end
      WAIT_DROP: begin
        if (!lk_s || drop_hit) state_nx = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (stab_hit) begin
          state_nx = FINISH;
        end else if (to_hit) begin
          state_nx = IDLE;
          err_nx   = 1'b1;
        end
      end
      FINISH: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    // gap holds the strobe low for one cycle after each completed write
    mgmt_write = wr_en && !gap;
    if (mgmt_write) begin
      mgmt_address   = wr_addr;
      mgmt_writedata = wr_data;
      if (!mgmt_waitrequest) begin
        state_nx = wr_next;
        gap_nx   = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hdmi_pll_reconfig_seq.sv
// Bench for hdmi_pll_reconfig_seq: random configs, bus stalls and lock
// behaviour checked against a spec-level expected write list and timing.
module tb_hdmi_pll_reconfig_seq;

  localparam int LS = 16;
  localparam int LT = 100;
  localparam int DW = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [8:0]  cfg_m = '0;
  logic [8:0]  cfg_n = '0;
  logic [8:0]  cfg_c0 = '0;
  logic [31:0] cfg_frac = '0;
  logic [5:0]  mgmt_address;
  logic        mgmt_write;
  logic [31:0] mgmt_writedata;
  logic        mgmt_waitrequest = 1'b0;
  logic        pll_locked = 1'b1;
  logic        busy;
  logic        done;
  logic        err;

  hdmi_pll_reconfig_seq #(
    .LOCK_STABLE(LS),
    .LOCK_TIMEOUT(LT),
    .DROP_WAIT(DW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_m(cfg_m),
    .cfg_n(cfg_n),
    .cfg_c0(cfg_c0),
    .cfg_frac(cfg_frac),
    .mgmt_address(mgmt_address),
    .mgmt_write(mgmt_write),
    .mgmt_writedata(mgmt_writedata),
    .mgmt_waitrequest(mgmt_waitrequest),
    .pll_locked(pll_locked),
    .busy(busy),
    .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  // 0: never stall, 1: random, 2: stall addr 4 five cycles, 4: stall addr 7
  int wr_mode = 0;
  int stall_n = 0;
  always @(posedge clk) begin
    #1;
    case (wr_mode)
      1: mgmt_waitrequest = 1'($urandom_range(0, 1));
      2: begin
        if (mgmt_write && mgmt_address == 6'd4 && stall_n < 5) begin
          mgmt_waitrequest = 1'b1;
          stall_n++;
        end else begin
          mgmt_waitrequest = 1'b0;
        end
      end
      4: mgmt_waitrequest = mgmt_write && mgmt_address == 6'd7;
      default: mgmt_waitrequest = 1'b0;
    endcase
  end

  // Bus and status observer
  int wcyc = 0;
  int wcyc4 = 0;
  int viol = 0;
  int done_n = 0;
  int err_n = 0;
  int done_cyc = 0;
  int err_cyc = 0;
  logic [5:0]  wa_q[$];
  logic [31:0] wd_q[$];
  int          wc_q[$];
  logic        p_wr = 1'b0;
  logic        p_wait = 1'b0;
  logic [5:0]  p_a = '0;
  logic [31:0] p_d = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      p_wr = 1'b0;
      p_wait = 1'b0;
    end else begin
      if (p_wr && p_wait && !(mgmt_write && mgmt_address == p_a &&
          mgmt_writedata == p_d)) viol++;
      if (p_wr && !p_wait && mgmt_write) viol++;
      if (done && err) viol++;
      if (mgmt_write) begin
        wcyc++;
        if (mgmt_address == 6'd4) wcyc4++;
        if (!mgmt_waitrequest) begin
          wa_q.push_back(mgmt_address);
          wd_q.push_back(mgmt_writedata);
          wc_q.push_back(cyc);
        end
      end
      if (done) begin
        done_n++;
        done_cyc = cyc;
      end
      if (err) begin
        err_n++;
        err_cyc = cyc;
      end
      p_wr = mgmt_write;
      p_wait = mgmt_waitrequest;
      p_a = mgmt_address;
      p_d = mgmt_writedata;
    end
  end

  function automatic logic [31:0] enc_ref(input int d);
    int lo;
    int hi;
    if (d == 1) return 32'h0001_0000;
    lo = d / 2;
    hi = (d - lo) % 256;
    return 32'((d % 2) * 131072 + hi * 256 + lo);
  endfunction

  function automatic int write_diffs(input int m, input int n,
                                     input int c, input logic [31:0] k);
    logic [5:0]  ea[6];
    logic [31:0] ed[6];
    int bad;
    bad = 0;
    ea = '{6'd0, 6'd3, 6'd4, 6'd5, 6'd7, 6'd2};
    ed = '{32'd0, enc_ref(n), enc_ref(m), enc_ref(c), k, 32'd1};
    if (wa_q.size() != 6) return 100 + wa_q.size();
    for (int i = 0; i < 6; i++)
      if (wa_q[i] !== ea[i] || wd_q[i] !== ed[i]) bad++;
    return bad;
  endfunction

  function automatic int rand_div();
    int pick[6];
    pick = '{1, 2, 255, 256, 257, 511};
    if ($urandom_range(0, 1) == 0) return pick[$urandom_range(0, 5)];
    return int'($urandom_range(1, 511));
  endfunction

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
    wc_q.delete();
  endtask

  task automatic send_cfg(input int m, input int n, input int c,
                          input logic [31:0] k, output int acc);
    int t;
    t = 0;
    @(posedge clk);
    #1;
    cfg_valid = 1'b1;
    cfg_m = 9'(m);
    cfg_n = 9'(n);
    cfg_c0 = 9'(c);
    cfg_frac = k;
    #1;
    while (!cfg_ready && t < 200) begin
      @(posedge clk);
      #2;
      t++;
    end
    checks++;
    if (cfg_ready !== 1'b1)
      $display("FAIL accept: cfg_ready=%b required 1", cfg_ready);
    else passes++;
    acc = cyc;
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    cfg_m = 9'($urandom);
    cfg_n = 9'($urandom);
    cfg_c0 = 9'($urandom);
    cfg_frac = $urandom;
  endtask

  task automatic wait_writes(input int n);
    int t;
    t = 0;
    while (wa_q.size() < n && t < 500) begin
      @(posedge clk);
      #2;
      t++;
    end
    checks++;
    if (wa_q.size() < n)
      $display("FAIL write_wait: writes=%0d required %0d", wa_q.size(), n);
    else passes++;
  endtask

  task automatic wait_end(input int d0, input int e0, input int bound);
    int t;
    t = 0;
    while (done_n == d0 && err_n == e0 && t < bound) begin
      @(posedge clk);
      #2;
      t++;
    end
    checks++;
    if (done_n == d0 && err_n == e0)
      $display("FAIL end_wait: no done/err within %0d cycles", bound);
    else passes++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({mgmt_write, mgmt_address, mgmt_writedata} !== 39'd0)
      $display("FAIL reset_bus: w=%b a=%h d=%h required 0",
               mgmt_write, mgmt_address, mgmt_writedata);
    else passes++;
    checks++;
    if ({busy, done, err, cfg_ready} !== 4'b0000)
      $display("FAIL reset_status: %b required 0000",
               {busy, done, err, cfg_ready});
    else passes++;
    rst_n = 1'b1;
    #1;
    checks++;
    if (cfg_ready !== 1'b0)
      $display("FAIL ready_pre_edge: %b required 0", cfg_ready);
    else passes++;
    @(posedge clk);
    #2;
    checks++;
    if (cfg_ready !== 1'b1)
      $display("FAIL ready_post_edge: %b required 1", cfg_ready);
    else passes++;
  endtask

  task automatic test_basic();
    int acc, d0, e0, rise, bad;
    clear_log();
    wr_mode = 0;
    pll_locked = 1'b1;
    d0 = done_n;
    e0 = err_n;
    send_cfg(8, 1, 3, 32'd3908420153, acc);
    wait_writes(6);
    pll_locked = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    pll_locked = 1'b1;
    rise = cyc;
    wait_end(d0, e0, 300);
    bad = write_diffs(8, 1, 3, 32'd3908420153);
    checks++;
    if (bad != 0) $display("FAIL basic_writes: diffs=%0d required 0", bad);
    else passes++;
    checks++;
    if (wa_q.size() != 6 || wd_q[1] !== 32'h00010000 ||
        wd_q[2] !== 32'h00000404 || wd_q[3] !== 32'h00020201)
      $display("FAIL basic_enc: n=%h m=%h c=%h required 10000/404/20201",
               wd_q[1], wd_q[2], wd_q[3]);
    else passes++;
    checks++;
    if (done_cyc - rise != 2 + LS)
      $display("FAIL basic_done_lat: %0d required %0d",
               done_cyc - rise, 2 + LS);
    else passes++;
    checks++;
    if (err_n != e0 || done_n != d0 + 1)
      $display("FAIL basic_pulses: done=%0d err=%0d required 1/0",
               done_n - d0, err_n - e0);
    else passes++;
    checks++;
    if (busy !== 1'b0 || cfg_ready !== 1'b1)
      $display("FAIL basic_idle: busy=%b ready=%b required 0/1",
               busy, cfg_ready);
    else passes++;
  endtask

  task automatic test_waitrequest();
    int acc, d0, e0, m, n, c, bad;
    logic [31:0] k;
    clear_log();
    wr_mode = 2;
    stall_n = 0;
    wcyc4 = 0;
    viol = 0;
    pll_locked = 1'b1;
    d0 = done_n;
    e0 = err_n;
    m = rand_div();
    n = rand_div();
    c = rand_div();
    k = $urandom;
    send_cfg(m, n, c, k, acc);
    wait_writes(6);
    wait_end(d0, e0, 300);
    bad = write_diffs(m, n, c, k);
    checks++;
    if (bad != 0) $display("FAIL stall_writes: diffs=%0d required 0", bad);
    else passes++;
    checks++;
    if (wcyc4 != 6)
      $display("FAIL stall_wr_m_cycles: %0d required 6", wcyc4);
    else passes++;
    checks++;
    if (viol != 0) $display("FAIL stall_protocol: viol=%0d required 0", viol);
    else passes++;
    checks++;
    if (wc_q.size() != 6 || done_cyc - wc_q[5] != 1 + DW + LS)
      $display("FAIL drop_timeout_lat: %0d required %0d",
               done_cyc - wc_q[wc_q.size() - 1], 1 + DW + LS);
    else passes++;
    wr_mode = 0;
  endtask

  task automatic test_random();
    int acc, d0, e0, m, n, c, bad, rise, path, lat, want;
    logic [31:0] k;
    for (int it = 0; it < 8; it++) begin
      clear_log();
      wr_mode = 1;
      viol = 0;
      pll_locked = 1'b1;
      d0 = done_n;
      e0 = err_n;
      m = rand_div();
      n = rand_div();
      c = rand_div();
      k = $urandom;
      path = int'($urandom_range(0, 1));
      send_cfg(m, n, c, k, acc);
      wait_writes(6);
      rise = 0;
      if (path == 1) begin
        pll_locked = 1'b0;
        repeat ($urandom_range(1, 8)) @(posedge clk);
        #1;
        pll_locked = 1'b1;
        rise = cyc;
      end
      wait_end(d0, e0, 300);
      bad = write_diffs(m, n, c, k);
      checks++;
      if (bad != 0 || viol != 0)
        $display("FAIL rand_writes[%0d]: diffs=%0d viol=%0d required 0/0",
                 it, bad, viol);
      else passes++;
      if (path == 1) begin
        lat = done_cyc - rise;
        want = 2 + LS;
      end else begin
        lat = (wc_q.size() == 6) ? done_cyc - wc_q[5] : -1;
        want = 1 + DW + LS;
      end
      checks++;
      if (lat != want || done_n != d0 + 1)
        $display("FAIL rand_done[%0d]: lat=%0d n=%0d required %0d/1",
                 it, lat, done_n - d0, want);
      else passes++;
    end
    wr_mode = 0;
  endtask

  task automatic test_illegal();
    int acc, e0, w0, m, n, c;
    for (int z = 0; z < 3; z++) begin
      e0 = err_n;
      w0 = wcyc;
      m = (z == 0) ? 0 : rand_div();
      n = (z == 1) ? 0 : rand_div();
      c = (z == 2) ? 0 : rand_div();
      send_cfg(m, n, c, $urandom, acc);
      repeat (2) @(posedge clk);
      #2;
      checks++;
      if (err_n != e0 + 1 || err_cyc != acc + 1)
        $display("FAIL illegal_err[%0d]: n=%0d at=%0d required 1 at %0d",
                 z, err_n - e0, err_cyc, acc + 1);
      else passes++;
      checks++;
      if (wcyc != w0 || cfg_ready !== 1'b1 || busy !== 1'b0)
        $display("FAIL illegal_idle[%0d]: wr=%0d rdy=%b busy=%b req 0/1/0",
                 z, wcyc - w0, cfg_ready, busy);
      else passes++;
    end
  endtask

  task automatic test_timeout();
    int acc, d0, e0;
    clear_log();
    wr_mode = 0;
    pll_locked = 1'b0;
    repeat (4) @(posedge clk);
    d0 = done_n;
    e0 = err_n;
    send_cfg(rand_div(), rand_div(), rand_div(), $urandom, acc);
    wait_writes(6);
    wait_end(d0, e0, 400);
    checks++;
    if (err_n != e0 + 1 || done_n != d0)
      $display("FAIL timeout_pulses: err=%0d done=%0d required 1/0",
               err_n - e0, done_n - d0);
    else passes++;
    checks++;
    if (wc_q.size() != 6 || err_cyc - wc_q[5] != 2 + LT)
      $display("FAIL timeout_lat: %0d required %0d",
               err_cyc - wc_q[wc_q.size() - 1], 2 + LT);
    else passes++;
    pll_locked = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_glitch();
    int acc, d0, e0, rise2;
    clear_log();
    pll_locked = 1'b1;
    d0 = done_n;
    e0 = err_n;
    send_cfg(rand_div(), rand_div(), rand_div(), $urandom, acc);
    wait_writes(6);
    pll_locked = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    pll_locked = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    pll_locked = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    pll_locked = 1'b1;
    rise2 = cyc;
    wait_end(d0, e0, 300);
    checks++;
    if (done_n != d0 + 1 || done_cyc - rise2 != 2 + LS)
      $display("FAIL glitch_done: n=%0d lat=%0d required 1/%0d",
               done_n - d0, done_cyc - rise2, 2 + LS);
    else passes++;
  endtask

  task automatic test_reset_midwrite();
    int acc, d0, e0, w0, t, m, n, c, bad;
    logic [31:0] k;
    clear_log();
    wr_mode = 4;
    pll_locked = 1'b1;
    send_cfg(rand_div(), rand_div(), rand_div(), $urandom, acc);
    t = 0;
    while (!(mgmt_write && mgmt_address == 6'd7) && t < 200) begin
      @(posedge clk);
      #2;
      t++;
    end
    checks++;
    if (!(mgmt_write && mgmt_address == 6'd7 && mgmt_waitrequest))
      $display("FAIL wr_k_reach: w=%b a=%0d required 1/7",
               mgmt_write, mgmt_address);
    else passes++;
    rst_n = 1'b0;
    #1;
    checks++;
    if (mgmt_write !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b0)
      $display("FAIL rst_abandon: w=%b busy=%b rdy=%b required 0/0/0",
               mgmt_write, busy, cfg_ready);
    else passes++;
    repeat (2) @(posedge clk);
    #1;
    wr_mode = 0;
    rst_n = 1'b1;
    w0 = wcyc;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (wcyc != w0 || cfg_ready !== 1'b1)
      $display("FAIL rst_no_resume: wr=%0d rdy=%b required 0/1",
               wcyc - w0, cfg_ready);
    else passes++;
    clear_log();
    d0 = done_n;
    e0 = err_n;
    m = rand_div();
    n = rand_div();
    c = rand_div();
    k = $urandom;
    send_cfg(m, n, c, k, acc);
    wait_writes(6);
    wait_end(d0, e0, 300);
    bad = write_diffs(m, n, c, k);
    checks++;
    if (bad != 0 || done_n != d0 + 1)
      $display("FAIL rst_new_cfg: diffs=%0d done=%0d required 0/1",
               bad, done_n - d0);
    else passes++;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_waitrequest();
    test_random();
    test_illegal();
    test_timeout();
    test_glitch();
    test_reset_midwrite();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
